// File: rtl/branch_predictor_pkg.sv
// Shared CPU definitions: PC width and 2-bit branch counter encoding.
package branch_predictor_pkg;

   localparam int CPU_PC_W = 16;
   localparam int CNT_W    = 16;

   localparam logic [1:0] CTR_SN = 2'b00;
   localparam logic [1:0] CTR_WN = 2'b01;
   localparam logic [1:0] CTR_WT = 2'b10;
   localparam logic [1:0] CTR_ST = 2'b11;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, ID-side resolve and statistics signals of the predictor.
interface branch_predictor_if #(
   parameter int PC_W = branch_predictor_pkg::CPU_PC_W
);
   logic            [PC_W-1:0] pc_i;
   logic                       stall_i;
   logic                       flush_i;
   logic                       prediction_o;
   logic            [PC_W-1:0] predtarget_o;
   logic                       pred_id_o;
   logic            [PC_W-1:0] idpc_i;
   logic                       ifbranch_i;
   logic            [PC_W-1:0] target_i;
   logic                       precorrc_i;
   logic                       prewrong_i;
   logic [branch_predictor_pkg::CNT_W-1:0] br_cnt_o;
   logic [branch_predictor_pkg::CNT_W-1:0] miss_cnt_o;

   modport master (
      output pc_i, stall_i, flush_i, idpc_i, ifbranch_i, target_i, precorrc_i, prewrong_i,
      input  prediction_o, predtarget_o, pred_id_o, br_cnt_o, miss_cnt_o
   );

   modport slave (
      input  pc_i, stall_i, flush_i, idpc_i, ifbranch_i, target_i, precorrc_i, prewrong_i,
      output prediction_o, predtarget_o, pred_id_o, br_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/branch_predictor_ctr2.sv
// Saturating 2-bit counter step: taken moves toward ST, not-taken toward SN.
module bp_ctr2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   // Next counter value, clamped at both ends.
   always_comb begin
      ctr_o = ctr_i;
      if (taken_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
      end else begin
         if (ctr_i != CTR_SN) ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup on the fetch PC,
// retrain on the resolved branch in ID, plus branch/miss statistics.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int PC_W  = CPU_PC_W,
   parameter int IDX_W = 4,
   parameter int TAG_W = PC_W - IDX_W
) (
   input  logic              CLK,
   input  logic              RST,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 1 << IDX_W;

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [PC_W-1:0]   target_q [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  lk_idx, up_idx;
   logic [TAG_W-1:0]  lk_tag, up_tag;
   logic              lk_hit, up_hit, upd;
   logic [1:0]        ctr_step;
   logic              pred_id_q;
   logic [CNT_W-1:0]  br_cnt_q, miss_cnt_q;

   assign lk_idx = bp.pc_i[IDX_W-1:0];
   assign lk_tag = bp.pc_i[PC_W-1:IDX_W];
   assign up_idx = bp.idpc_i[IDX_W-1:0];
   assign up_tag = bp.idpc_i[PC_W-1:IDX_W];

   // Lookup reads the stored entry only; a same-cycle update is not bypassed.
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
   assign upd    = bp.precorrc_i || bp.prewrong_i;

   assign bp.prediction_o = lk_hit && ctr_q[lk_idx][1];
   assign bp.predtarget_o = lk_hit ? target_q[lk_idx] : '0;
   assign bp.pred_id_o    = pred_id_q;
   assign bp.br_cnt_o     = br_cnt_q;
   assign bp.miss_cnt_o   = miss_cnt_q;

   bp_ctr2 u_ctr2 (
      .ctr_i   (ctr_q[up_idx]),
      .taken_i (bp.ifbranch_i),
      .ctr_o   (ctr_step)
   );

   // Table retrain: hits step the counter, taken misses allocate at WT.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WN;
         end
      end else if (upd) begin
         if (up_hit) begin
            ctr_q[up_idx] <= ctr_step;
            if (bp.ifbranch_i) target_q[up_idx] <= bp.target_i;
         end else if (bp.ifbranch_i) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bp.target_i;
            ctr_q[up_idx]    <= CTR_WT;
         end
      end
   end

   // Prediction travels alongside the IF/ID register; flush wins over stall.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)            pred_id_q <= 1'b0;
      else if (bp.flush_i) pred_id_q <= 1'b0;
      else if (!bp.stall_i) pred_id_q <= bp.prediction_o;
   end

   // Statistics; both-high resolve counts as a misprediction.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (upd)           br_cnt_q   <= br_cnt_q + 1'b1;
         if (bp.prewrong_i) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter hysteresis,
// aliasing, no-bypass, IF/ID alignment and asynchronous reset.
module tb_branch_predictor;

   logic CLK;
   logic RST;
   int   checks   = 0;
   int   failures = 0;

   branch_predictor_if bp ();

   branch_predictor dut (
      .CLK (CLK),
      .RST (RST),
      .bp  (bp)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic do_update(input logic [15:0] pc, input logic taken,
                            input logic [15:0] tgt, input logic wrong);
      @(negedge CLK);
      bp.idpc_i     = pc;
      bp.ifbranch_i = taken;
      bp.target_i   = tgt;
      bp.precorrc_i = !wrong;
      bp.prewrong_i = wrong;
      @(negedge CLK);
      bp.precorrc_i = 1'b0;
      bp.prewrong_i = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      bp.pc_i = 16'h0013;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL reset_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0000) begin failures++; $display("FAIL reset_target got=%0h exp=0", bp.predtarget_o); end
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL reset_pred_id got=%0h exp=0", bp.pred_id_o); end
      checks++; if (bp.br_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_br got=%0d exp=0", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_miss got=%0d exp=0", bp.miss_cnt_o); end
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL cold_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL cold_pred_id got=%0h exp=0", bp.pred_id_o); end
   endtask

   task automatic test_allocate();
      do_update(16'h0013, 1'b1, 16'h0040, 1'b1);
      bp.pc_i = 16'h0013;
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL alloc_pred got=%0h exp=1", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0040) begin failures++; $display("FAIL alloc_target got=%0h exp=0040", bp.predtarget_o); end
      checks++; if (bp.br_cnt_o !== 16'd1) begin failures++; $display("FAIL alloc_br got=%0d exp=1", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd1) begin failures++; $display("FAIL alloc_miss got=%0d exp=1", bp.miss_cnt_o); end
   endtask

   task automatic test_saturation();
      // WT -> ST -> ST
      do_update(16'h0013, 1'b1, 16'h0040, 1'b0);
      do_update(16'h0013, 1'b1, 16'h0040, 1'b0);
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL sat_st_pred got=%0h exp=1", bp.prediction_o); end
      checks++; if (bp.br_cnt_o !== 16'd3) begin failures++; $display("FAIL sat_st_br got=%0d exp=3", bp.br_cnt_o); end
      // ST -> WT
      do_update(16'h0013, 1'b0, 16'h0999, 1'b1);
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL sat_wt_pred got=%0h exp=1", bp.prediction_o); end
      // WT -> WN, target unchanged on not-taken
      do_update(16'h0013, 1'b0, 16'h0999, 1'b1);
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL sat_wn_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0040) begin failures++; $display("FAIL sat_wn_target got=%0h exp=0040", bp.predtarget_o); end
      // WN -> SN -> SN -> SN
      for (int i = 0; i < 3; i++) do_update(16'h0013, 1'b0, 16'h0000, 1'b0);
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL sat_sn_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.br_cnt_o !== 16'd8) begin failures++; $display("FAIL sat_sn_br got=%0d exp=8", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd3) begin failures++; $display("FAIL sat_sn_miss got=%0d exp=3", bp.miss_cnt_o); end
      // SN -> WN: still not taken proves the floor held
      do_update(16'h0013, 1'b1, 16'h0040, 1'b1);
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL sat_floor_pred got=%0h exp=0", bp.prediction_o); end
      // WN -> WT with target overwrite
      do_update(16'h0013, 1'b1, 16'h0055, 1'b1);
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL retarget_pred got=%0h exp=1", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0055) begin failures++; $display("FAIL retarget_target got=%0h exp=0055", bp.predtarget_o); end
      checks++; if (bp.br_cnt_o !== 16'd10) begin failures++; $display("FAIL retarget_br got=%0d exp=10", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd5) begin failures++; $display("FAIL retarget_miss got=%0d exp=5", bp.miss_cnt_o); end
   endtask

   task automatic test_alias();
      do_update(16'h0023, 1'b1, 16'h0077, 1'b1);
      bp.pc_i = 16'h0013;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL alias_old_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0000) begin failures++; $display("FAIL alias_old_target got=%0h exp=0", bp.predtarget_o); end
      bp.pc_i = 16'h0023;
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL alias_new_pred got=%0h exp=1", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0077) begin failures++; $display("FAIL alias_new_target got=%0h exp=0077", bp.predtarget_o); end
      // Not-taken miss must not allocate or disturb the aliasing entry.
      do_update(16'h0033, 1'b0, 16'h0099, 1'b0);
      bp.pc_i = 16'h0033;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL nt_miss_pred got=%0h exp=0", bp.prediction_o); end
      bp.pc_i = 16'h0023;
      #1;
      checks++; if (bp.predtarget_o !== 16'h0077) begin failures++; $display("FAIL nt_miss_keep got=%0h exp=0077", bp.predtarget_o); end
      checks++; if (bp.br_cnt_o !== 16'd12) begin failures++; $display("FAIL nt_miss_br got=%0d exp=12", bp.br_cnt_o); end
   endtask

   task automatic test_same_cycle();
      @(negedge CLK);
      bp.pc_i       = 16'h0023;
      bp.idpc_i     = 16'h0023;
      bp.ifbranch_i = 1'b0;
      bp.target_i   = 16'h0000;
      bp.precorrc_i = 1'b1;
      bp.prewrong_i = 1'b1;
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL nobypass_pred got=%0h exp=1", bp.prediction_o); end
      @(negedge CLK);
      bp.precorrc_i = 1'b0;
      bp.prewrong_i = 1'b0;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL after_upd_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0077) begin failures++; $display("FAIL after_upd_target got=%0h exp=0077", bp.predtarget_o); end
      checks++; if (bp.br_cnt_o !== 16'd13) begin failures++; $display("FAIL both_high_br got=%0d exp=13", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd7) begin failures++; $display("FAIL both_high_miss got=%0d exp=7", bp.miss_cnt_o); end
   endtask

   task automatic test_pipeline();
      do_update(16'h0005, 1'b1, 16'h0100, 1'b1);
      bp.pc_i    = 16'h0013;
      bp.stall_i = 1'b0;
      bp.flush_i = 1'b0;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL pipe_load0 got=%0h exp=0", bp.pred_id_o); end
      bp.pc_i    = 16'h0005;
      bp.stall_i = 1'b1;
      #1;
      checks++; if (bp.prediction_o !== 1'b1) begin failures++; $display("FAIL pipe_pred got=%0h exp=1", bp.prediction_o); end
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL pipe_stall_hold cyc=%0d got=%0h exp=0", i, bp.pred_id_o); end
      end
      bp.stall_i = 1'b0;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b1) begin failures++; $display("FAIL pipe_load1 got=%0h exp=1", bp.pred_id_o); end
      bp.stall_i = 1'b1;
      bp.flush_i = 1'b1;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL pipe_flush_stall got=%0h exp=0", bp.pred_id_o); end
      bp.stall_i = 1'b0;
      bp.flush_i = 1'b0;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b1) begin failures++; $display("FAIL pipe_reload got=%0h exp=1", bp.pred_id_o); end
      bp.flush_i = 1'b1;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL pipe_flush got=%0h exp=0", bp.pred_id_o); end
      bp.flush_i = 1'b0;
      @(negedge CLK);
      checks++; if (bp.pred_id_o !== 1'b1) begin failures++; $display("FAIL pipe_pre_reset got=%0h exp=1", bp.pred_id_o); end
   endtask

   task automatic test_async_reset();
      bp.idpc_i     = 16'h0023;
      bp.ifbranch_i = 1'b1;
      bp.target_i   = 16'h0200;
      bp.prewrong_i = 1'b1;
      #2;
      RST = 1'b0;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL arst_pred got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.predtarget_o !== 16'h0000) begin failures++; $display("FAIL arst_target got=%0h exp=0", bp.predtarget_o); end
      checks++; if (bp.pred_id_o !== 1'b0) begin failures++; $display("FAIL arst_pred_id got=%0h exp=0", bp.pred_id_o); end
      checks++; if (bp.br_cnt_o !== 16'd0) begin failures++; $display("FAIL arst_br got=%0d exp=0", bp.br_cnt_o); end
      checks++; if (bp.miss_cnt_o !== 16'd0) begin failures++; $display("FAIL arst_miss got=%0d exp=0", bp.miss_cnt_o); end
      #4;
      RST = 1'b1;
      @(negedge CLK);
      bp.prewrong_i = 1'b0;
      bp.ifbranch_i = 1'b0;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL arst_old_hit got=%0h exp=0", bp.prediction_o); end
      bp.pc_i = 16'h0023;
      #1;
      checks++; if (bp.prediction_o !== 1'b0) begin failures++; $display("FAIL arst_lost_upd got=%0h exp=0", bp.prediction_o); end
      checks++; if (bp.br_cnt_o !== 16'd0) begin failures++; $display("FAIL arst_br_after got=%0d exp=0", bp.br_cnt_o); end
   endtask

   initial begin
      RST           = 1'b0;
      bp.pc_i       = '0;
      bp.stall_i    = 1'b0;
      bp.flush_i    = 1'b0;
      bp.idpc_i     = '0;
      bp.ifbranch_i = 1'b0;
      bp.target_i   = '0;
      bp.precorrc_i = 1'b0;
      bp.prewrong_i = 1'b0;
      test_reset();
      test_allocate();
      test_saturation();
      test_alias();
      test_same_cycle();
      test_pipeline();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
